// File: rtl/apb_initiator_if.sv
// Request/response port and APB3/APB4 requester bus of apb_initiator.
// master = the initiator itself, slave = the environment around it.
interface apb_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  rsp_ready,
        output out_paddr, out_psel, out_penable, out_pprot,
        output out_pwrite, out_pwdata, out_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output rsp_ready,
        input  out_paddr, out_psel, out_penable, out_pprot,
        input  out_pwrite, out_pwdata, out_pstrb,
        output in_pready, in_prdata, in_pslverr
    );
endinterface

// File: rtl/apb_initiator.sv
// APB requester: one outstanding valid/ready request -> SETUP/ACCESS transfer,
// buffered response with backpressure and an ACCESS-phase timeout abort.
module apb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic            clock,
    input logic            reset,
    apb_initiator_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

    state_e      state_q;
    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pstrb_q;
    logic [2:0]  pprot_q;
    logic        psel_q;
    logic        penable_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic        rsp_timeout_q;
    logic [15:0] cnt_q;
    logic [16:0] cnt_d;
    logic        to_hit;

    // Wait-cycle count including this one; abort on the TIMEOUT-th wait.
    assign cnt_d  = {1'b0, cnt_q} + 17'd1;
    assign to_hit = (TO_LIM != 17'd0) && (cnt_d == TO_LIM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        paddr_q  <= bus.req_addr;
                        pwrite_q <= bus.req_write;
                        pwdata_q <= bus.req_wdata;
                        pprot_q  <= bus.req_prot;
                        pstrb_q  <= bus.req_write ? bus.req_wstrb : 4'b0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.in_pready) begin
                        rsp_rdata_q   <= pwrite_q ? 32'h0 : bus.in_prdata;
                        rsp_error_q   <= bus.in_pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_d[15:0];
                        if (to_hit) begin
                            rsp_rdata_q   <= 32'h0;
                            rsp_error_q   <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.out_paddr   = paddr_q;
    assign bus.out_psel    = psel_q;
    assign bus.out_penable = penable_q;
    assign bus.out_pprot   = pprot_q;
    assign bus.out_pwrite  = pwrite_q;
    assign bus.out_pwdata  = pwdata_q;
    assign bus.out_pstrb   = pstrb_q;
endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed corner cases plus random transfers
// checked against a transaction-level model of the expected response.
module tb_apb_initiator;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    apb_initiator_if bus ();

    apb_initiator #(.TIMEOUT(TO)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request and leave the bench at the negedge of ACCESS cycle 1.
    task automatic to_access(input logic [31:0] a, input logic w);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'hf;
        bus.req_prot  = 3'd2;
        bus.in_pready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transfer; the response expectation comes from the outcome
    // rules: ready on wait cycle waits+1 unless the timeout expires first.
    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [2:0] pr, input int waits,
                        input logic serr, input logic [31:0] rd,
                        input int bp);
        int          done_k;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_to;
        logic [3:0]  exp_strb;
        exp_strb = w ? ws : 4'h0;
        if (waits < TO) begin
            done_k  = waits + 1;
            exp_rd  = w ? 32'h0 : rd;
            exp_err = serr;
            exp_to  = 1'b0;
        end else begin
            done_k  = TO;
            exp_rd  = 32'h0;
            exp_err = 1'b1;
            exp_to  = 1'b1;
        end
        chk("idle_req_ready", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        bus.req_prot  = pr;
        @(posedge clk);
        @(negedge clk);
        chk("setup_psel", 32'(bus.out_psel), 1);
        chk("setup_penable", 32'(bus.out_penable), 0);
        chk("setup_req_ready", 32'(bus.req_ready), 0);
        chk("setup_paddr", bus.out_paddr, a);
        chk("setup_pwrite", 32'(bus.out_pwrite), 32'(w));
        chk("setup_pwdata", bus.out_pwdata, wd);
        chk("setup_pstrb", 32'(bus.out_pstrb), 32'(exp_strb));
        chk("setup_pprot", 32'(bus.out_pprot), 32'(pr));
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom);
        @(posedge clk);
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            chk("acc_psel", 32'(bus.out_psel), 1);
            chk("acc_penable", 32'(bus.out_penable), 1);
            chk("acc_paddr", bus.out_paddr, a);
            chk("acc_pwdata", bus.out_pwdata, wd);
            chk("acc_pstrb", 32'(bus.out_pstrb), 32'(exp_strb));
            chk("acc_rsp_valid", 32'(bus.rsp_valid), 0);
            bus.in_pready  = (k == waits + 1);
            bus.in_pslverr = (k == waits + 1) ? serr : 1'($urandom);
            bus.in_prdata  = (k == waits + 1) ? rd : $urandom;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_pready  = 1'b0;
        bus.in_pslverr = 1'($urandom);
        bus.in_prdata  = $urandom;
        chk("rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_error", 32'(bus.rsp_error), 32'(exp_err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
        chk("done_psel", 32'(bus.out_psel), 0);
        chk("done_penable", 32'(bus.out_penable), 0);
        chk("done_paddr_kept", bus.out_paddr, a);
        chk("resp_req_ready", 32'(bus.req_ready), 0);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("bp_rsp_error", 32'(bus.rsp_error), 32'(exp_err));
            chk("bp_rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
            chk("bp_req_ready", 32'(bus.req_ready), 0);
            chk("bp_psel", 32'(bus.out_psel), 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("post_req_ready", 32'(bus.req_ready), 1);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_write  = 1'b0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.req_prot   = '0;
        bus.rsp_ready  = 1'b0;
        bus.in_pready  = 1'b0;
        bus.in_prdata  = '0;
        bus.in_pslverr = 1'b0;
        #1;
        chk("rst_psel", 32'(bus.out_psel), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_paddr", bus.out_paddr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rel_req_ready", 32'(bus.req_ready), 1);

        // Zero-wait read.
        xfer(32'h8000_0010, 1'b0, 32'h0, 4'hf, 3'd0, 0, 1'b0,
             32'hDEAD_BEEF, 0);
        // Write, 3 wait states: ready lands on the timeout cycle itself.
        xfer(32'h0000_0040, 1'b1, 32'h1234_5678, 4'b0110, 3'd1, 3, 1'b0,
             32'hFFFF_FFFF, 0);
        // Slave error with ready; then error only while not ready.
        xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0, 3'd0, 1, 1'b1,
             32'h5555_AAAA, 0);
        xfer(32'h0000_0104, 1'b0, 32'h0, 4'h0, 3'd0, 2, 1'b0,
             32'h0BAD_F00D, 0);
        // Timeout, ready never comes.
        xfer(32'h0000_0200, 1'b0, 32'h0, 4'h0, 3'd7, 50, 1'b0,
             32'h1111_1111, 0);
        // Backpressure for 10 cycles.
        xfer(32'h0000_0300, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0,
             32'hCAFE_0001, 10);

        // Asynchronous reset in the middle of ACCESS.
        to_access(32'hA5A5_0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", 32'(bus.out_psel), 0);
        chk("mid_rst_penable", 32'(bus.out_penable), 0);
        chk("mid_rst_paddr", bus.out_paddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rel_req_ready", 32'(bus.req_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(bus.rsp_valid), 0);
            chk("mid_no_psel", 32'(bus.out_psel), 0);
        end

        // Asynchronous reset while a response is held.
        to_access(32'h0000_0400, 1'b0);
        bus.in_pready  = 1'b1;
        bus.in_pslverr = 1'b1;
        bus.in_prdata  = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        bus.in_pready  = 1'b0;
        bus.in_pslverr = 1'b0;
        chk("hold_rsp_valid", 32'(bus.rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rsprst_valid", 32'(bus.rsp_valid), 0);
        chk("rsprst_error", 32'(bus.rsp_error), 0);
        chk("rsprst_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rsprst_req_ready", 32'(bus.req_ready), 1);

        for (int n = 0; n < 40; n++) begin
            xfer($urandom, 1'($urandom), $urandom, 4'($urandom),
                 3'($urandom), int'($urandom_range(0, 6)), 1'($urandom),
                 $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
